// File: rtl/sd_block_receiver.sv
// SD single-block receiver: hunts the start token, buffers one block, checks CRC16 and streams the block out only on a match.
// out_valid rises 2 cycles after the last CRC byte is accepted; an out register plus a skid register keep 1 byte/cycle under backpressure.
module sd_block_receiver #(
  parameter int         BLOCK_LENGTH_BYTES  = 512,
  parameter int         TOKEN_TIMEOUT_BYTES = 1024,
  parameter logic [7:0] START_TOKEN         = 8'hFE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_last,
  input  logic       out_ready,
  output logic       busy,
  output logic       done,
  output logic       crc_ok,
  output logic       timeout,
  output logic       token_error
);

  localparam int AW = $clog2(BLOCK_LENGTH_BYTES);
  localparam int CW = AW + 1;
  localparam int FW = $clog2(TOKEN_TIMEOUT_BYTES) + 1;
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(BLOCK_LENGTH_BYTES - 1);
  localparam logic [CW-1:0] CNT_END   = CW'(BLOCK_LENGTH_BYTES);
  localparam logic [FW-1:0] FILL_ONE  = FW'(1);
  localparam logic [FW-1:0] FILL_LAST = FW'(TOKEN_TIMEOUT_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_HUNT, S_DATA, S_CRC_HI, S_CRC_LO, S_DRAIN
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [FW-1:0] fill_q, fill_d;
  logic [15:0]   crc_q, crc_d;
  logic [7:0]    crc_hi_q, crc_hi_d;
  logic          crc_ok_q, crc_ok_d;
  logic          timeout_q, timeout_d;
  logic          token_err_q, token_err_d;
  logic          done_q, done_d;

  logic          wr_en, rd_issue, pop, crc_match;
  logic [1:0]    occ;
  logic [7:0]    mem_q [BLOCK_LENGTH_BYTES];
  logic [7:0]    ram_dout_q;
  logic          rd_pend_q, ram_last_q;
  logic          out_valid_q, out_last_q, skid_vld_q, skid_last_q;
  logic [7:0]    out_data_q, skid_data_q;

  function automatic logic [15:0] crc16_upd(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {d, 8'h00};
    for (int i = 0; i < 8; i++) begin
      r = r[15] ? ({r[14:0], 1'b0} ^ 16'h1021) : {r[14:0], 1'b0};
    end
    return r;
  endfunction

  assign crc_match = ({crc_hi_q, in_data} == crc_q);
  assign pop       = out_valid_q && out_ready;
  // Items held or in flight after this cycle's pop; out + skid can hold two.
  assign occ       = 2'(out_valid_q) + 2'(skid_vld_q) + 2'(rd_pend_q) - 2'(pop);
  // The first read is issued with the last CRC byte so out_valid rises two cycles later.
  assign rd_issue  = ((state_q == S_CRC_LO) && in_valid && crc_match) ||
                     ((state_q == S_DRAIN) && (cnt_q != CNT_END) && (occ < 2'd2));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    fill_d      = fill_q;
    crc_d       = crc_q;
    crc_hi_d    = crc_hi_q;
    crc_ok_d    = crc_ok_q;
    timeout_d   = timeout_q;
    token_err_d = token_err_q;
    done_d      = 1'b0;
    wr_en       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          crc_ok_d    = 1'b0;
          timeout_d   = 1'b0;
          token_err_d = 1'b0;
          crc_d       = '0;
          cnt_d       = '0;
          fill_d      = '0;
          state_d     = S_HUNT;
        end
      end
      S_HUNT: begin
        if (in_valid) begin
          if (in_data == START_TOKEN) begin
            state_d = S_DATA;
          end else if (in_data[7:4] == 4'h0) begin
            token_err_d = 1'b1;
            done_d      = 1'b1;
            state_d     = S_IDLE;
          end else begin
            fill_d = fill_q + FILL_ONE;
            if (fill_q == FILL_LAST) begin
              timeout_d = 1'b1;
              done_d    = 1'b1;
              state_d   = S_IDLE;
            end
          end
        end
      end
      S_DATA: begin
        if (in_valid) begin
          wr_en = 1'b1;
          crc_d = crc16_upd(crc_q, in_data);
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = S_CRC_HI;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      S_CRC_HI: begin
        if (in_valid) begin
          crc_hi_d = in_data;
          state_d  = S_CRC_LO;
        end
      end
      S_CRC_LO: begin
        if (in_valid) begin
          if (crc_match) begin
            crc_ok_d = 1'b1;
            cnt_d    = cnt_q + CNT_ONE;
            state_d  = S_DRAIN;
          end else begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_DRAIN: begin
        if (rd_issue) cnt_d = cnt_q + CNT_ONE;
        if (pop && out_last_q) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Block buffer: no reset, registered read, so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[cnt_q[AW-1:0]] <= in_data;
    if (rd_issue) ram_dout_q <= mem_q[cnt_q[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      fill_q      <= '0;
      crc_q       <= '0;
      crc_hi_q    <= '0;
      crc_ok_q    <= 1'b0;
      timeout_q   <= 1'b0;
      token_err_q <= 1'b0;
      done_q      <= 1'b0;
      rd_pend_q   <= 1'b0;
      ram_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      skid_vld_q  <= 1'b0;
      skid_data_q <= '0;
      skid_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      fill_q      <= fill_d;
      crc_q       <= crc_d;
      crc_hi_q    <= crc_hi_d;
      crc_ok_q    <= crc_ok_d;
      timeout_q   <= timeout_d;
      token_err_q <= token_err_d;
      done_q      <= done_d;
      rd_pend_q   <= rd_issue;
      if (rd_issue) ram_last_q <= (cnt_q == CNT_LAST);
      // Oldest byte lives in the out register, then skid, then RAM output.
      if (!out_valid_q || pop) begin
        if (skid_vld_q) begin
          out_valid_q <= 1'b1;
          out_data_q  <= skid_data_q;
          out_last_q  <= skid_last_q;
          skid_vld_q  <= rd_pend_q;
          skid_data_q <= ram_dout_q;
          skid_last_q <= ram_last_q;
        end else if (rd_pend_q) begin
          out_valid_q <= 1'b1;
          out_data_q  <= ram_dout_q;
          out_last_q  <= ram_last_q;
        end else begin
          out_valid_q <= 1'b0;
        end
      end else if (rd_pend_q) begin
        skid_vld_q  <= 1'b1;
        skid_data_q <= ram_dout_q;
        skid_last_q <= ram_last_q;
      end
    end
  end

  assign in_ready    = (state_q == S_HUNT) || (state_q == S_DATA) ||
                       (state_q == S_CRC_HI) || (state_q == S_CRC_LO);
  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign crc_ok      = crc_ok_q;
  assign timeout     = timeout_q;
  assign token_error = token_err_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_last    = out_last_q;

endmodule

// File: tb/tb_sd_block_receiver.sv
// Directed bench for sd_block_receiver: table of block scenarios plus a mid-block reset sequence.
module tb_sd_block_receiver;

  logic       clk = 1'b0;
  logic       rst, start, in_valid, out_ready;
  logic [7:0] in_data;
  logic       in_ready, out_valid, out_last, busy, done, crc_ok, timeout, token_error;
  logic [7:0] out_data;

  sd_block_receiver dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready), .busy(busy), .done(done), .crc_ok(crc_ok),
    .timeout(timeout), .token_error(token_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         kind;       // 0 all 8'hFF, 1 ramp i[7:0], 2 random
    int         n_fill;
    logic       has_tok;
    logic [7:0] tok;
    logic       use_model;
    logic [15:0] crc;
    logic [7:0] crc_flip;
    logic       gaps;
    logic       rnd_rdy;
    logic       exp_ok;
    logic       exp_to;
    logic       exp_te;
    int         exp_out;
  } vec_t;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] blk [512];
  logic [7:0] got_dat [$];
  logic       got_last [$];
  int         vcyc, donecnt;
  logic       gaps_en = 1'b0;
  logic       rnd_rdy = 1'b0;
  vec_t       vecs [6];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [15:0] crc_bit(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    logic fb;
    r = c;
    for (int k = 7; k >= 0; k--) begin
      fb = r[15] ^ d[k];
      r  = {r[14:0], 1'b0};
      if (fb) r = r ^ 16'h1021;
    end
    return r;
  endfunction

  initial begin
    forever begin
      @(posedge clk); #1;
      out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Output monitor: records accepted bytes and verifies holding during stalls.
  initial begin
    logic       stall_prev;
    logic [7:0] prev_dat;
    logic       prev_last;
    stall_prev = 1'b0;
    prev_dat   = '0;
    prev_last  = 1'b0;
    forever begin
      @(negedge clk);
      if (stall_prev && !rst)
        chk("stall_hold", int'({out_valid, out_last, out_data}), int'({1'b1, prev_last, prev_dat}));
      if (out_valid) vcyc++;
      if (out_valid && out_ready) begin
        got_dat.push_back(out_data);
        got_last.push_back(out_last);
      end
      if (done) donecnt++;
      stall_prev = out_valid && !out_ready && !rst;
      prev_dat   = out_data;
      prev_last  = out_last;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    if (gaps_en) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!in_ready) begin
      chk("in_ready_wait", 0, 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    logic [15:0] c;
    int mism, lastcnt, n;
    got_dat.delete();
    got_last.delete();
    vcyc    = 0;
    donecnt = 0;
    gaps_en = v.gaps;
    rnd_rdy = v.rnd_rdy;
    for (int i = 0; i < 512; i++) begin
      case (v.kind)
        0:       blk[i] = 8'hFF;
        1:       blk[i] = 8'(i);
        default: blk[i] = 8'($urandom_range(1, 255));
      endcase
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("in_ready_after_start", in_ready, 1);
    for (int i = 0; i < v.n_fill; i++) send_byte(8'hFF);
    if (v.has_tok) begin
      send_byte(v.tok);
      if (v.tok == 8'hFE) begin
        c = 16'h0000;
        for (int i = 0; i < 512; i++) begin
          send_byte(blk[i]);
          c = crc_bit(c, blk[i]);
        end
        if (!v.use_model) c = v.crc;
        send_byte(c[15:8]);
        send_byte(c[7:0] ^ v.crc_flip);
      end
    end
    if (v.exp_ok) begin
      chk("out_valid_lat1", out_valid, 0);
      @(posedge clk); #1;
      chk("out_valid_lat2", out_valid, 1);
      n = 0;
      while (!done && n < 20000) begin @(posedge clk); #1; n++; end
      chk("done_seen", done, 1);
    end else begin
      chk("done_next_cycle", done, 1);
    end
    chk("busy_at_done", busy, 0);
    chk("crc_ok", crc_ok, int'(v.exp_ok));
    chk("timeout", timeout, int'(v.exp_to));
    chk("token_error", token_error, int'(v.exp_te));
    if (v.exp_to) chk("in_ready_dropped", in_ready, 0);
    rnd_rdy = 1'b0;
    gaps_en = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("done_pulses", donecnt, 1);
    chk("out_count", got_dat.size(), v.exp_out);
    if (v.exp_out == 0) begin
      chk("valid_cycles", vcyc, 0);
    end else begin
      mism = 0;
      lastcnt = 0;
      for (int i = 0; i < got_dat.size(); i++) begin
        if (i < 512 && got_dat[i] !== blk[i]) mism++;
        if (got_last[i]) lastcnt++;
      end
      chk("data_seq_mismatches", mism, 0);
      chk("last_count", lastcnt, 1);
      chk("last_on_final", int'(got_last[got_last.size()-1]), 1);
    end
  endtask

  initial begin
    // kind fill tok? tok model crc flip gaps rrdy ok to te out
    vecs[0] = '{0, 3,    1'b1, 8'hFE, 1'b0, 16'h7FA1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 512};
    vecs[1] = '{1, 0,    1'b1, 8'hFE, 1'b1, 16'h0000, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    vecs[2] = '{0, 2,    1'b1, 8'h05, 1'b1, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0};
    vecs[3] = '{0, 1024, 1'b0, 8'h00, 1'b1, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0};
    vecs[4] = '{2, 5,    1'b1, 8'hFE, 1'b1, 16'h0000, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 512};
    vecs[5] = '{1, 1,    1'b1, 8'hFE, 1'b1, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 512};

    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_flags", int'({crc_ok, timeout, token_error, out_last}), 0);

    for (int t = 0; t < 5; t++) run_vec(vecs[t]);

    // Reset while byte 200 of a block is being offered.
    donecnt = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    send_byte(8'hFE);
    for (int i = 0; i < 200; i++) send_byte(8'(i + 1));
    in_valid = 1'b1;
    in_data  = 8'hAA;
    rst      = 1'b1;
    @(posedge clk); #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_data", out_data, 0);
    chk("mid_rst_out_last", out_last, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_flags", int'({crc_ok, timeout, token_error}), 0);
    repeat (3) begin @(posedge clk); #1; end
    chk("mid_rst_no_done", donecnt, 0);
    run_vec(vecs[5]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
